// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues consecutive word pairs to a dual-port ROM,
// queues the returned words and hands them to decode one per cycle.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 4,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] rom_addr_a,
  output logic [31:0] rom_addr_b,
  input  logic [31:0] rom_data_a,
  input  logic [31:0] rom_data_b,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned AW = CW + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   req_pc;
  logic          req_pend;
  logic [PW-1:0] rptr;
  logic [PW-1:0] wptr;
  logic [CW-1:0] count;
  logic [31:0]   q_pc   [QDEPTH];
  logic [31:0]   q_word [QDEPTH];

  logic          issue;
  logic          push;
  logic          pop;
  logic [AW-1:0] used;
  logic          unused_bits;

  assign unused_bits = ^redirect_pc[1:0];

  // Credit check counts queued entries plus the pair still in flight; a pop
  // this cycle is deliberately not credited.
  assign used  = AW'(count) + (req_pend ? AW'(2) : AW'(0));
  assign issue = redirect_valid || (used <= AW'(QDEPTH - 2));
  assign push  = req_pend && !redirect_valid;
  assign pop   = inst_valid && inst_ready;

  assign rom_addr_a = redirect_valid ? {redirect_pc[31:2], 2'b00} : fetch_pc;
  assign rom_addr_b = rom_addr_a + 32'd4;

  assign inst_valid = (count != '0);
  assign inst_data  = inst_valid ? q_word[rptr] : NOP;
  assign inst_pc    = inst_valid ? q_pc[rptr]   : 32'd0;

  // Fetch pointer, in-flight tracking and queue bookkeeping; redirect flushes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      req_pend <= 1'b0;
      rptr     <= '0;
      wptr     <= '0;
      count    <= '0;
    end else begin
      req_pend <= issue;
      if (issue) begin
        req_pc   <= rom_addr_a;
        fetch_pc <= rom_addr_a + 32'd8;
      end
      if (redirect_valid) begin
        rptr  <= '0;
        wptr  <= '0;
        count <= '0;
      end else begin
        if (push) wptr <= wptr + PW'(2);
        if (pop)  rptr <= rptr + PW'(1);
        count <= count + (push ? CW'(2) : CW'(0)) - (pop ? CW'(1) : CW'(0));
      end
    end
  end

  // Queue storage needs no reset: entries are only visible while count != 0.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wptr]              <= req_pc;
      q_word[wptr]            <= rom_data_a;
      q_pc[wptr + PW'(1)]     <= req_pc + 32'd4;
      q_word[wptr + PW'(1)]   <= rom_data_b;
    end
  end

  assert property (@(posedge clk) disable iff (!reset) push |-> (count <= CW'(QDEPTH - 2)));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed timing scenarios plus randomized ready/redirect
// traffic checked against an in-order instruction stream model.
module tb_fetch_unit;

  localparam logic [31:0] NOP_W = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic [31:0] rom_addr_a;
  logic [31:0] rom_addr_b;
  logic [31:0] rom_data_a;
  logic [31:0] rom_data_b;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          n_deliv  = 0;
  logic [31:0] exp_pc   = 32'h0;

  fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .QDEPTH  (4),
    .NOP     (NOP_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rom_addr_a    (rom_addr_a),
    .rom_addr_b    (rom_addr_b),
    .rom_data_a    (rom_data_a),
    .rom_data_b    (rom_data_b),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst_data     (inst_data),
    .inst_pc       (inst_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Loop program in the low 64 bytes; everything else reads as NOP.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a >= 32'h40) return NOP_W;
    case (a[5:2])
      4'd0:  return 32'hfe010113;
      4'd1:  return 32'h00112e23;
      4'd2:  return 32'h00812c23;
      4'd3:  return 32'h02010413;
      4'd4:  return 32'hfea42623;
      4'd5:  return 32'hfe042783;
      4'd6:  return 32'h00f50533;
      4'd7:  return 32'h00178793;
      4'd8:  return 32'hfe842783;
      4'd9:  return 32'h00a7d463;
      4'd10: return 32'hfe5ff06f;
      4'd11: return 32'h00000513;
      4'd12: return 32'h01c12083;
      4'd13: return 32'h01812403;
      4'd14: return 32'h02010113;
      default: return 32'h00008067;
    endcase
  endfunction

  always @(posedge clk) begin
    rom_data_a <= rom_word(rom_addr_a);
    rom_data_b <= rom_word(rom_addr_b);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    n_assert++;
    assert (obs === expd) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, expd);
    end
  endtask

  // One cycle: drive inputs mid-cycle, then check the stream model.
  task automatic cyc(input logic rdy, input logic rv, input logic [31:0] rpc);
    @(negedge clk);
    inst_ready     = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
    if (rv) chk("redirect_addr", rom_addr_a, {rpc[31:2], 2'b00});
    if (inst_valid) begin
      if (rdy) begin
        chk("stream_pc", inst_pc, exp_pc);
        chk("stream_data", inst_data, rom_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        n_deliv++;
      end
    end else begin
      chk("empty_data", inst_data, NOP_W);
      chk("empty_pc", inst_pc, 32'h0);
    end
    if (rv) exp_pc = {rpc[31:2], 2'b00};
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    #1;
    chk("reset_valid", 32'(inst_valid), 32'h0);
    chk("reset_addr_a", rom_addr_a, 32'h0);
    chk("reset_addr_b", rom_addr_b, 32'h4);
    chk("reset_data", inst_data, NOP_W);
    chk("reset_pc", inst_pc, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    exp_pc = 32'h0;
  endtask

  task automatic cold_start();
    cyc(1'b1, 1'b0, 32'h0);
    chk("c0_addr_a", rom_addr_a, 32'h0);
    chk("c0_addr_b", rom_addr_b, 32'h4);
    chk("c0_valid", 32'(inst_valid), 32'h0);
    cyc(1'b1, 1'b0, 32'h0);
    chk("c1_addr_a", rom_addr_a, 32'h8);
    chk("c1_addr_b", rom_addr_b, 32'hc);
    chk("c1_valid", 32'(inst_valid), 32'h0);
    cyc(1'b1, 1'b0, 32'h0);
    chk("c2_valid", 32'(inst_valid), 32'h1);
    chk("c2_pc", inst_pc, 32'h0);
    chk("c2_data", inst_data, 32'hfe010113);
    cyc(1'b1, 1'b0, 32'h0);
    chk("c3_pc", inst_pc, 32'h4);
    chk("c3_data", inst_data, 32'h00112e23);
    cyc(1'b1, 1'b0, 32'h0);
    chk("c4_pc", inst_pc, 32'h8);
    chk("c4_data", inst_data, 32'h00812c23);
  endtask

  initial begin
    reset          = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    // Cold start
    do_reset();
    cold_start();

    // Backpressure: queue fills, head holds, then drains in order without gaps
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b0, 32'h0);
      if (i >= 2) begin
        chk("bp_hold_valid", 32'(inst_valid), 32'h1);
        chk("bp_hold_pc", inst_pc, 32'h0);
      end
    end
    chk("bp_fetch_stalled", rom_addr_a, 32'h10);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b0, 32'h0);
      chk("bp_drain_valid", 32'(inst_valid), 32'h1);
      chk("bp_drain_pc", inst_pc, 32'(i * 4));
    end

    // Redirect to unaligned 0x21 with an entry queued and a pair in flight
    do_reset();
    repeat (5) cyc(1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 32'h21);
    chk("rd_addr_a", rom_addr_a, 32'h20);
    chk("rd_addr_b", rom_addr_b, 32'h24);
    cyc(1'b1, 1'b0, 32'h0);
    chk("rd_next_valid", 32'(inst_valid), 32'h0);
    cyc(1'b1, 1'b0, 32'h0);
    chk("rd_tgt_valid", 32'(inst_valid), 32'h1);
    chk("rd_tgt_pc", inst_pc, 32'h20);
    chk("rd_tgt_data", inst_data, 32'hfe842783);
    cyc(1'b1, 1'b0, 32'h0);
    chk("rd_tgt2_pc", inst_pc, 32'h24);

    // Redirect coinciding with the pop of 0x10
    do_reset();
    repeat (6) cyc(1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 32'h30);
    chk("rp_pop_valid", 32'(inst_valid), 32'h1);
    chk("rp_pop_pc", inst_pc, 32'h10);
    cyc(1'b1, 1'b0, 32'h0);
    chk("rp_gap_valid", 32'(inst_valid), 32'h0);
    cyc(1'b1, 1'b0, 32'h0);
    chk("rp_tgt_valid", 32'(inst_valid), 32'h1);
    chk("rp_tgt_pc", inst_pc, 32'h30);

    // Reset mid-stream with three entries queued, then identical cold start
    do_reset();
    repeat (3) cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0);
    chk("mid_head_pc", inst_pc, 32'h4);
    do_reset();
    cold_start();

    // Address wrap through 2^32
    cyc(1'b1, 1'b1, 32'hfffffff8);
    cyc(1'b1, 1'b0, 32'h0);
    chk("wrap_gap_valid", 32'(inst_valid), 32'h0);
    cyc(1'b1, 1'b0, 32'h0);
    chk("wrap_pc0", inst_pc, 32'hfffffff8);
    chk("wrap_data0", inst_data, NOP_W);
    cyc(1'b1, 1'b0, 32'h0);
    chk("wrap_pc1", inst_pc, 32'hfffffffc);
    cyc(1'b1, 1'b0, 32'h0);
    chk("wrap_pc2", inst_pc, 32'h0);
    chk("wrap_data2", inst_data, 32'hfe010113);
    cyc(1'b1, 1'b0, 32'h0);
    chk("wrap_pc3", inst_pc, 32'h4);

    // Randomized ready and redirect traffic against the stream model
    do_reset();
    n_deliv = 0;
    for (int i = 0; i < 3000; i++) begin
      logic        rdy;
      logic        rv;
      logic [31:0] rpc;
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 1) == 0) rpc = 32'($urandom_range(0, 127));
      else                           rpc = 32'hffffffe0 + 32'($urandom_range(0, 31));
      cyc(rdy, rv, rpc);
    end
    chk("rand_throughput", 32'(n_deliv > 500), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
